mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port `memory` block between the instruction-fetch port and the load/store data port of the core. Each cycle it grants at most one request, drives the memory strobes combinationally from the granted port, and routes the one-cycle-latency read data back to the port that issued the read. It sits between the core and `memory`, so a single memory array can serve a von Neumann memory map.

## Interface
- `ADDR_W`, 32: address width on all ports.
- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous reset, active-low.
- `if_req_i` input 1: instruction fetch read request.
- `if_addr_i` input ADDR_W: fetch byte address.
- `if_gnt_o` output 1: fetch request accepted this cycle.
- `if_rvalid_o` output 1: `if_rdata_o` is valid this cycle.
- `if_rdata_o` output 32: fetch read data.
- `d_req_i` input 1: data request. Read if `d_wmask_i == 0`, otherwise write.
- `d_addr_i` input ADDR_W: data byte address.
- `d_wmask_i` input 4: byte write mask.
- `d_wdata_i` input 32: write data.
- `d_gnt_o` output 1: data request accepted this cycle.
- `d_rvalid_o` output 1: `d_rdata_o` is valid this cycle.
- `d_rdata_o` output 32: data read data.
- `mem_addr_o` output 32: to memory; zero-extended from ADDR_W.
- `mem_rstrb_o` output 1: to memory read strobe.
- `mem_wmask_o` output 4: to memory byte write mask.
- `mem_wdata_o` output 32: to memory write data.
- `mem_rdata_i` input 32: from memory; valid the cycle after `mem_rstrb_o`.

## Operation
- **Requester rule:** hold `*_req_i` and all payload stable until `*_gnt_o` is seen high. The arbiter never withdraws a grant.
- **Grant:** `if_gnt_o` and `d_gnt_o` are combinational and mutually exclusive. A grant is issued whenever at least one request is pending; there are no bubbles.
- **Memory drive:**
  - Granted fetch: `mem_addr_o = if_addr_i`, `mem_rstrb_o = 1`, `mem_wmask_o = 0`.
  - Granted data read: `mem_rstrb_o = 1`, `mem_wmask_o = 0`.
  - Granted data write: `mem_rstrb_o = 0`, `mem_wmask_o = d_wmask_i`, `mem_wdata_o = d_wdata_i`. The write completes at the grant edge and gets no response.
  - No grant: `mem_rstrb_o = 0`, `mem_wmask_o = 0`, `mem_addr_o` holds the last granted address.
- **Read-return FSM:** register `rd_owner`, states `IDLE`, `RD_IF`, `RD_D`.
  - Entered at the edge after a read grant: fetch → `RD_IF`, data read → `RD_D`.
  - Otherwise next state is `IDLE`.
  - A new grant may coincide with any state (fully pipelined).
- **Return path:**
  - `if_rvalid_o = (state == RD_IF)`.
  - `d_rvalid_o = (state == RD_D)`.
  - Both `*_rdata_o = mem_rdata_i`. Data is meaningful only while the matching rvalid is high.
- **Address width:** only `mem_addr_o[ADDR_W-1:0]` is driven from the port; the upper bits are 0.
- **Reset:** asynchronous assert forces state `IDLE`, address register 0, and priority pointer to favour data. An in-flight read is dropped, and no rvalid follows reset release.
- **Reset outputs:** all `*_gnt_o`, `*_rvalid_o`, `mem_rstrb_o`, and `mem_wmask_o` are 0 during reset, regardless of requests.

## Timing
- **Read latency:** grant in cycle N, rvalid in cycle N+1. Read-data latency is therefore 1 cycle after grant.
- **Throughput:** one access per cycle. Back-to-back reads from alternating ports return in grant order.
- **Simultaneous requests:** exactly one is granted per the arbitration policy (see Configuration). The loser is granted in the next cycle at the earliest.
- **Write then read:** a data write granted in N followed by a read of the same word granted in N+1 returns the new data in N+2.
- **Read during write:** a fetch granted in N+1 after a data write in N sees the written data.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - **Defined:** round-robin. A 1-bit `last_gnt` register records the port granted most recently. When both request, the other port wins. When only one requests, it is granted and `last_gnt` is updated.
  - **Undefined:** fixed priority, data port always wins. `last_gnt` is not implemented. Fetch may starve while data requests persist.

## Test plan
- **Reset:** assert `rst_n = 0` mid-read while `if_req_i = 1` → all gnt/rvalid/strobe outputs are 0 immediately. After release, the pending fetch is granted next cycle and no stale rvalid appears.
- **Single fetch:** preload word 0x10 = 0xDEADBEEF, fetch addr 0x10 → `if_gnt_o` in N, `if_rvalid_o` in N+1 with `if_rdata_o = 0xDEADBEEF`. `d_rvalid_o` stays 0.
- **Byte write then read:**
  - Write `d_addr 0x20`, wmask 4'b0010, wdata 0x0000AB00 over existing 0x11223344.
  - Then a data read of 0x20 → `d_rdata_o = 0x1122AB44`.
  - No rvalid for the write.
- **Contention, fixed priority:** both request continuously for 4 cycles → `d_gnt_o` every cycle, `if_gnt_o` never.
- **Contention, round robin:** same stimulus with `MEM_ARB_ROUND_ROBIN_EN` defined → grants alternate D, IF, D, IF. Rvalids alternate one cycle later with the correct per-port data.
- **Pipelining:** fetch 0x0 and data read 0x4 on consecutive cycles → rvalids on consecutive cycles, each port receiving only its own word.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port and the load/store data port. Grants at most one request per cycle,
// drives the memory strobes combinationally from the granted port, and
// steers the one-cycle-latency read data back to the port that issued it.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// without it the data port has fixed priority over fetch.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   if_req_i/if_addr_i           fetch read request and byte address
//   if_gnt_o                     fetch accepted this cycle (combinational)
//   if_rvalid_o/if_rdata_o       fetch read return
//   d_req_i/d_addr_i             data request and byte address
//   d_wmask_i/d_wdata_i          byte write mask (0 = read) and write data
//   d_gnt_o                      data accepted this cycle (combinational)
//   d_rvalid_o/d_rdata_o         data read return
//   mem_addr_o/mem_rstrb_o       memory address and read strobe
//   mem_wmask_o/mem_wdata_o      memory byte write mask and write data
//   mem_rdata_i                  memory read data, valid the cycle after rstrb
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [3:0]        d_wmask_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic [31:0]       mem_addr_o,
  output logic              mem_rstrb_o,
  output logic [3:0]        mem_wmask_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_D  = 2'd2
  } rd_owner_e;

  rd_owner_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              if_gnt_c, d_gnt_c;
  logic              d_read_c;
  logic [ADDR_W-1:0] sel_addr_c;

  assign d_read_c = (d_wmask_i == 4'b0000);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = data port was granted most recently; reset value favours data.
  logic last_gnt_q, last_gnt_d;

  // Round-robin grant: on contention the port not granted last wins.
  always_comb begin
    if_gnt_c   = 1'b0;
    d_gnt_c    = 1'b0;
    last_gnt_d = last_gnt_q;
    if (rst_n) begin
      if (if_req_i && d_req_i) begin
        if (last_gnt_q) if_gnt_c = 1'b1;
        else            d_gnt_c  = 1'b1;
      end else begin
        if_gnt_c = if_req_i;
        d_gnt_c  = d_req_i;
      end
    end
    if (d_gnt_c)       last_gnt_d = 1'b1;
    else if (if_gnt_c) last_gnt_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_gnt_q <= 1'b0;
    else        last_gnt_q <= last_gnt_d;
  end
`else
  // Fixed priority: data always wins; rst_n gating keeps grants low in reset.
  always_comb begin
    d_gnt_c  = rst_n & d_req_i;
    if_gnt_c = rst_n & if_req_i & ~d_req_i;
  end
`endif

  // Memory drive, address hold and read-owner next state.
  always_comb begin
    state_d     = IDLE;
    addr_d      = addr_q;
    sel_addr_c  = addr_q;
    mem_rstrb_o = 1'b0;
    mem_wmask_o = 4'b0000;
    mem_wdata_o = d_wdata_i;
    if (if_gnt_c) begin
      sel_addr_c  = if_addr_i;
      addr_d      = if_addr_i;
      mem_rstrb_o = 1'b1;
      state_d     = RD_IF;
    end else if (d_gnt_c) begin
      sel_addr_c = d_addr_i;
      addr_d     = d_addr_i;
      if (d_read_c) begin
        mem_rstrb_o = 1'b1;
        state_d     = RD_D;
      end else begin
        mem_wmask_o = d_wmask_i;
      end
    end
    mem_addr_o = 32'(sel_addr_c);
  end

  // Read-owner and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign if_gnt_o    = if_gnt_c;
  assign d_gnt_o     = d_gnt_c;
  assign if_rvalid_o = (state_q == RD_IF);
  assign d_rvalid_o  = (state_q == RD_D);
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized requesters for
// mem_arbiter, checked against a transaction-level reference model that
// predicts grants from the arbitration policy and read data from its own
// copy of memory contents. Define MEM_ARB_ROUND_ROBIN_EN to model round-robin.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic              if_gnt_o, if_rvalid_o;
  logic [31:0]       if_rdata_o;
  logic              d_req_i = 1'b0;
  logic [ADDR_W-1:0] d_addr_i = '0;
  logic [3:0]        d_wmask_i = '0;
  logic [31:0]       d_wdata_i = '0;
  logic              d_gnt_o, d_rvalid_o;
  logic [31:0]       d_rdata_o;
  logic [31:0]       mem_addr_o;
  logic              mem_rstrb_o;
  logic [3:0]        mem_wmask_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i = '0;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_wmask_i(d_wmask_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_rstrb_o(mem_rstrb_o),
    .mem_wmask_o(mem_wmask_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT: 64 words, one-cycle read latency.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (mem_rstrb_o) mem_rdata_i <= mem[mem_addr_o[7:2]];
    for (int b = 0; b < 4; b++)
      if (mem_wmask_o[b]) mem[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
  end

  // Reference model state.
  logic [31:0] ref_mem [64];
  logic [31:0] ref_addr;
  bit          ref_last_d;
  bit          last_if_g, last_d_g;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input bit ireq, input logic [31:0] iaddr, input bit dreq,
                       input logic [31:0] daddr, input logic [3:0] dmask,
                       input logic [31:0] dwdata);
    if_req_i  = ireq;
    if_addr_i = ADDR_W'(iaddr);
    d_req_i   = dreq;
    d_addr_i  = ADDR_W'(daddr);
    d_wmask_i = dmask;
    d_wdata_i = dwdata;
  endtask

  // One cycle: called just after a falling edge with inputs applied; ends on
  // the next falling edge after checking the read return.
  task automatic step();
    bit          g_if, g_d, d_rd;
    logic [31:0] ga, exp_rd;
    #1;
    g_if = 1'b0;
    g_d  = 1'b0;
    if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (ref_last_d) g_if = 1'b1;
      else            g_d  = 1'b1;
`else
      g_d = 1'b1;
`endif
    end else begin
      g_if = if_req_i;
      g_d  = d_req_i;
    end
    d_rd = g_d && (d_wmask_i == 4'b0000);
    check("if_gnt", 32'(if_gnt_o), 32'(g_if));
    check("d_gnt", 32'(d_gnt_o), 32'(g_d));
    check("mem_rstrb", 32'(mem_rstrb_o), 32'(g_if | d_rd));
    check("mem_wmask", 32'(mem_wmask_o), (g_d && !d_rd) ? 32'(d_wmask_i) : 32'h0);
    if (g_if)     ga = 32'(if_addr_i);
    else if (g_d) ga = 32'(d_addr_i);
    else          ga = ref_addr;
    check("mem_addr", mem_addr_o, ga);
    if (g_d && !d_rd) begin
      check("mem_wdata", mem_wdata_o, d_wdata_i);
      for (int b = 0; b < 4; b++)
        if (d_wmask_i[b]) ref_mem[ga[7:2]][8*b +: 8] = d_wdata_i[8*b +: 8];
    end
    exp_rd = ref_mem[ga[7:2]];
    if (g_if || g_d) ref_addr = ga;
    if (g_d)       ref_last_d = 1'b1;
    else if (g_if) ref_last_d = 1'b0;
    last_if_g = g_if;
    last_d_g  = g_d;
    @(posedge clk);
    @(negedge clk);
    check("if_rvalid", 32'(if_rvalid_o), 32'(g_if));
    check("d_rvalid", 32'(d_rvalid_o), 32'(d_rd));
    if (g_if) check("if_rdata", if_rdata_o, exp_rd);
    if (d_rd) check("d_rdata", d_rdata_o, exp_rd);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_if_gnt"}, 32'(if_gnt_o), 32'h0);
    check({tag, "_d_gnt"}, 32'(d_gnt_o), 32'h0);
    check({tag, "_if_rvalid"}, 32'(if_rvalid_o), 32'h0);
    check({tag, "_d_rvalid"}, 32'(d_rvalid_o), 32'h0);
    check({tag, "_rstrb"}, 32'(mem_rstrb_o), 32'h0);
    check({tag, "_wmask"}, 32'(mem_wmask_o), 32'h0);
    check({tag, "_addr"}, mem_addr_o, 32'h0);
  endtask

  initial begin
    bit          if_pend, d_pend;
    logic [31:0] ia, da, dw;
    logic [3:0]  dm;

    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
    ref_addr   = 32'h0;
    ref_last_d = 1'b0;

    // Reset with both ports requesting: everything quiet.
    drive(1'b1, 32'h10, 1'b1, 32'h20, 4'hF, 32'h12345678);
    #2;
    check_quiet("rst0");
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst_n = 1'b1;

    // Idle cycle: address stays at reset value.
    step();

    // Single fetch of preloaded word.
    drive(1'b1, 32'h10, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    check("fetch_deadbeef", if_rdata_o, 32'hDEADBEEF);

    // Byte write then read back the merged word.
    drive(1'b0, 32'h0, 1'b1, 32'h20, 4'b0010, 32'h0000AB00);
    step();
    drive(1'b0, 32'h0, 1'b1, 32'h20, 4'b0000, 32'h0);
    step();
    check("byte_merge", d_rdata_o, 32'h1122AB44);

    // Contention for four cycles.
    drive(1'b1, 32'h0, 1'b1, 32'h4, 4'h0, 32'h0);
    repeat (4) step();

    // Pipelined fetch then data read.
    drive(1'b1, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b1, 32'h4, 4'h0, 32'h0);
    step();

    // Full-word write followed by a fetch of the same word.
    drive(1'b0, 32'h0, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D);
    step();
    drive(1'b1, 32'h30, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    check("raw_fetch", if_rdata_o, 32'hCAFEF00D);

    // Reset asserted mid-read with requests still pending.
    drive(1'b1, 32'h10, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    d_req_i = 1'b1;
    d_wmask_i = 4'hF;
    #1;
    check_quiet("rst_mid");
    @(negedge clk);
    d_req_i = 1'b0;
    d_wmask_i = 4'h0;
    rst_n = 1'b1;
    ref_addr   = 32'h0;
    ref_last_d = 1'b0;
    check("rst_stale_if_rvalid", 32'(if_rvalid_o), 32'h0);
    step();

    // Randomized requesters obeying the hold-until-grant rule.
    if_pend = 1'b0;
    d_pend  = 1'b0;
    ia = 32'h0; da = 32'h0; dw = 32'h0; dm = 4'h0;
    for (int c = 0; c < 600; c++) begin
      if (!if_pend && ($urandom_range(3) != 0)) begin
        if_pend = 1'b1;
        ia = {24'h0, 6'($urandom_range(63)), 2'b00};
      end
      if (!d_pend && ($urandom_range(3) != 0)) begin
        d_pend = 1'b1;
        da = {24'h0, 6'($urandom_range(63)), 2'b00};
        dm = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
        dw = $urandom;
      end
      drive(if_pend, ia, d_pend, da, dm, dw);
      step();
      if (last_if_g) if_pend = 1'b0;
      if (last_d_g)  d_pend  = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
